// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared types and constants for the VRAM write scheduler:
//   mem_sel_e      - target graphics memory, bit position in render_req/mem_we
//   *_SIZE         - number of valid word offsets in each memory region
//   fifo_entry_t   - decoded host write as stored in the write FIFO
//   head_state_e   - status of the FIFO head (empty / issuing / stalled)
//   region_offset_ok() - true when an offset is inside the selected region
// ---------------------------------------------------------------------------
package vram_pkg;

    typedef enum logic [2:0] {
        TILE_BUF   = 3'd0,
        TILE_GFX   = 3'd1,
        SPRITE_GFX = 3'd2,
        PALETTE    = 3'd3,
        OAM        = 3'd4
    } mem_sel_e;

    localparam int unsigned TILE_BUF_SIZE   = 300;
    localparam int unsigned TILE_GFX_SIZE   = 2048;
    localparam int unsigned SPRITE_GFX_SIZE = 2048;
    localparam int unsigned PALETTE_SIZE    = 8;
    localparam int unsigned OAM_SIZE        = 256;

    typedef struct packed {
        mem_sel_e    sel;
        logic [10:0] offset;
        logic [31:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } head_state_e;

    // Regions 5..7 never match. Offsets are widened to 32 bits so that the
    // 2048-entry limits compare correctly against an 11-bit offset.
    function automatic logic region_offset_ok(input logic [2:0] region,
                                              input logic [10:0] offset);
        logic ok;
        ok = 1'b0;
        case (region)
            3'd0:    ok = 32'(offset) < TILE_BUF_SIZE;
            3'd1:    ok = 32'(offset) < TILE_GFX_SIZE;
            3'd2:    ok = 32'(offset) < SPRITE_GFX_SIZE;
            3'd3:    ok = 32'(offset) < PALETTE_SIZE;
            3'd4:    ok = 32'(offset) < OAM_SIZE;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head view so that a freshly pushed
// entry is visible at the head on the following cycle.
// Ports:
//   clk, reset (sync, active-low)
//   push, push_data  - enqueue (caller guarantees not full)
//   pop              - dequeue the head (caller guarantees not empty)
//   head_data        - current head entry
//   level            - occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign level     = r_level;

endmodule

// File: rtl/vram_write_scheduler.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler
// Buffers host writes to the graphics memories and commits them in order,
// one per cycle, whenever the renderer has not reserved the target memory.
// Palette and OAM commits additionally wait for vertical blank.
// Ports:
//   clk, reset (sync, active-low)
//   host_write/host_addr/host_writedata/host_waitrequest - host slave side
//   render_req[4:0] - per-memory reservation for the next cycle
//   vblank          - vertical blank window
//   mem_we[4:0], wr_addr, wr_data - registered one-hot write bus
//   fifo_level      - queued entries
//   drop_count      - saturating count of rejected (invalid) writes
// ---------------------------------------------------------------------------
import vram_pkg::*;

module vram_write_scheduler #(
    parameter int DEPTH = 16,
    parameter int AW    = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_write,
    input  logic [AW-1:0]          host_addr,
    input  logic [31:0]            host_writedata,
    output logic                   host_waitrequest,
    input  logic [4:0]             render_req,
    input  logic                   vblank,
    output logic [4:0]             mem_we,
    output logic [10:0]            wr_addr,
    output logic [31:0]            wr_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_count
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [2:0]         w_region;
    logic [10:0]        w_offset;
    logic               w_accept;
    logic               w_addr_ok;
    logic               w_push;
    logic               w_drop;
    fifo_entry_t        w_push_entry;
    logic [ENTRY_W-1:0] w_head_bits;
    fifo_entry_t        w_head;
    logic [LW-1:0]      w_level;
    logic [LW-1:0]      w_level_next;
    logic               w_head_valid;
    logic               w_needs_vblank;
    logic               w_eligible;
    logic               w_pop;

    head_state_e        r_state;
    logic [4:0]         r_mem_we;
    logic [10:0]        r_wr_addr;
    logic [31:0]        r_wr_data;
    logic               r_full;
    logic [7:0]         r_drop_count;

    // Decode at enqueue; invalid writes finish the handshake but are dropped.
    assign w_region     = host_addr[13:11];
    assign w_offset     = host_addr[10:0];
    assign w_accept     = host_write && !r_full;
    assign w_addr_ok    = region_offset_ok(w_region, w_offset);
    assign w_push       = w_accept && w_addr_ok;
    assign w_drop       = w_accept && !w_addr_ok;
    assign w_push_entry = '{sel: mem_sel_e'(w_region), offset: w_offset, data: host_writedata};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head_bits),
        .level     (w_level)
    );

    assign w_head = w_head_bits;

    // r_state tracks head presence; it is EMPTY exactly when the level is 0.
    assign w_head_valid   = (r_state != ST_EMPTY);
    assign w_needs_vblank = (w_head.sel == PALETTE) || (w_head.sel == OAM);
    assign w_eligible     = !render_req[w_head.sel] && (!w_needs_vblank || vblank);
    assign w_pop          = w_head_valid && w_eligible;

    assign w_level_next = w_level + {{(LW-1){1'b0}}, w_push} - {{(LW-1){1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_EMPTY;
            r_mem_we     <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_full       <= 1'b0;
            r_drop_count <= '0;
        end else begin
            // A new head is presumed issuable; the next cycle's eligibility
            // moves it between ISSUE and STALL.
            case (r_state)
                ST_EMPTY: begin
                    if (w_level_next != '0) r_state <= ST_ISSUE;
                end
                ST_ISSUE, ST_STALL: begin
                    if (w_level_next == '0) r_state <= ST_EMPTY;
                    else if (w_pop)         r_state <= ST_ISSUE;
                    else                    r_state <= ST_STALL;
                end
                default: r_state <= ST_EMPTY;
            endcase

            r_mem_we <= w_pop ? (5'b00001 << w_head.sel) : 5'b00000;
            if (w_pop) begin
                r_wr_addr <= w_head.offset;
                r_wr_data <= w_head.data;
            end

            // Full is derived from the post-edge level only, so a pop while
            // full still leaves the host waiting this cycle.
            r_full <= (w_level_next == LW'(DEPTH));

            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign host_waitrequest = r_full;
    assign mem_we           = r_mem_we;
    assign wr_addr          = r_wr_addr;
    assign wr_data          = r_wr_data;
    assign fifo_level       = w_level;
    assign drop_count       = r_drop_count;

endmodule
